// File: rtl/mem_port_arbiter_if.sv
// Bundle of the cache-side request/response signals and the main-memory port signals.
// Latency: none, wires only.
// Backpressure: requesters hold req until their done pulse; memory stalls by holding m_rdy low.
//
// Signals:
//   i_req/i_addr                   I-cache line-read request
//   d_req/d_wr/d_addr/d_wdata      D-cache fill or write-back request
//   m_rdy/m_rdata                  memory completion and read line
//   m_re/m_we/m_addr/m_wdata       memory strobes, line address and write data
//   rdata/i_done/d_done/err        line and completion pulses returned to the caches
// Modports: slave = arbiter view, master = environment (caches + memory) view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [13:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [13:0] d_addr;
    logic [63:0] d_wdata;
    logic        m_rdy;
    logic [63:0] m_rdata;
    logic        m_re;
    logic        m_we;
    logic [13:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] rdata;
    logic        i_done;
    logic        d_done;
    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdy, m_rdata,
        output m_re, m_we, m_addr, m_wdata, rdata, i_done, d_done, err
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdy, m_rdata,
        input  m_re, m_we, m_addr, m_wdata, rdata, i_done, d_done, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory line port between the I-cache fill path and the D-cache fill/write-back path.
// Latency: grant edge + at least one BUSY cycle + one RESP cycle (3 cycles minimum per transaction).
// Backpressure: one transaction in flight; the losing requester holds req and is granted in the next IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset; drops any in-flight transaction without a done pulse
//   bus    mem_port_arbiter_if.slave (cache requests, memory port, done/err/rdata back to the caches)
// Parameter TIMEOUT (2..255): BUSY cycles without m_rdy before the transaction is aborted with err.
// Build option RR_ARB_EN: round-robin on simultaneous requests; otherwise D-cache has fixed priority.
// All outputs come straight from flops; there is no combinational input-to-output path.
module mem_port_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  timer, timer_nxt;
    // 1 = D-cache was granted last, 0 = I-cache; also selects which done fires in RESP
    logic        last_gnt_d, last_gnt_d_nxt;

    logic        m_re_q, m_re_nxt;
    logic        m_we_q, m_we_nxt;
    logic [13:0] m_addr_q, m_addr_nxt;
    logic [63:0] m_wdata_q, m_wdata_nxt;
    logic [63:0] rdata_q, rdata_nxt;
    logic        i_done_q, i_done_nxt;
    logic        d_done_q, d_done_nxt;
    logic        err_q, err_nxt;

    logic        any_req;
    logic        grant_d;
    logic        timeout_hit;

    assign any_req     = bus.i_req | bus.d_req;
    // m_rdy wins over the watchdog when both land on the same edge
    assign timeout_hit = (timer == TIMER_LAST) && !bus.m_rdy;

`ifdef RR_ARB_EN
    // On a tie, hand the port to whichever side did not have it last
    assign grant_d = bus.d_req && (!bus.i_req || !last_gnt_d);
`else
    assign grant_d = bus.d_req;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            last_gnt_d <= 1'b0;
            m_re_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            rdata_q    <= '0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            last_gnt_d <= last_gnt_d_nxt;
            m_re_q     <= m_re_nxt;
            m_we_q     <= m_we_nxt;
            m_addr_q   <= m_addr_nxt;
            m_wdata_q  <= m_wdata_nxt;
            rdata_q    <= rdata_nxt;
            i_done_q   <= i_done_nxt;
            d_done_q   <= d_done_nxt;
            err_q      <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req) state_nxt = ST_BUSY;
            ST_BUSY: if (bus.m_rdy || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the datapath
    always_comb begin
        timer_nxt      = timer;
        last_gnt_d_nxt = last_gnt_d;
        m_re_nxt       = m_re_q;
        m_we_nxt       = m_we_q;
        m_addr_nxt     = m_addr_q;
        m_wdata_nxt    = m_wdata_q;
        rdata_nxt      = rdata_q;
        i_done_nxt     = i_done_q;
        d_done_nxt     = d_done_q;
        err_nxt        = err_q;

        case (state)
            ST_IDLE: begin
                i_done_nxt = 1'b0;
                d_done_nxt = 1'b0;
                err_nxt    = 1'b0;
                if (any_req) begin
                    last_gnt_d_nxt = grant_d;
                    timer_nxt      = '0;
                    if (grant_d) begin
                        m_addr_nxt  = bus.d_addr;
                        m_wdata_nxt = bus.d_wdata;
                        m_we_nxt    = bus.d_wr;
                        m_re_nxt    = !bus.d_wr;
                    end else begin
                        // I-cache has no write data; m_wdata keeps its last value
                        m_addr_nxt = bus.i_addr;
                        m_we_nxt   = 1'b0;
                        m_re_nxt   = 1'b1;
                    end
                end else begin
                    m_re_nxt = 1'b0;
                    m_we_nxt = 1'b0;
                end
            end

            ST_BUSY: begin
                if (bus.m_rdy) begin
                    // Write-backs capture m_rdata too; the caller ignores rdata then
                    rdata_nxt  = bus.m_rdata;
                    m_re_nxt   = 1'b0;
                    m_we_nxt   = 1'b0;
                    err_nxt    = 1'b0;
                    i_done_nxt = !last_gnt_d;
                    d_done_nxt = last_gnt_d;
                end else if (timeout_hit) begin
                    rdata_nxt  = '0;
                    m_re_nxt   = 1'b0;
                    m_we_nxt   = 1'b0;
                    err_nxt    = 1'b1;
                    i_done_nxt = !last_gnt_d;
                    d_done_nxt = last_gnt_d;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end

            ST_RESP: begin
                i_done_nxt = 1'b0;
                d_done_nxt = 1'b0;
                err_nxt    = 1'b0;
            end

            default: begin
                m_re_nxt   = 1'b0;
                m_we_nxt   = 1'b0;
                i_done_nxt = 1'b0;
                d_done_nxt = 1'b0;
                err_nxt    = 1'b0;
            end
        endcase
    end

    assign bus.m_re    = m_re_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.rdata   = rdata_q;
    assign bus.i_done  = i_done_q;
    assign bus.d_done  = d_done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed cases followed by randomized request/latency rounds.
// Expected behaviour comes from a transaction-level model (winner rule, strobe length, done/err/rdata).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int TO = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   last_d;   // model: 1 = D was granted last

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".m_re"},    64'(bus.m_re),   64'd0);
        chk({tag, ".m_we"},    64'(bus.m_we),   64'd0);
        chk({tag, ".m_addr"},  64'(bus.m_addr), 64'd0);
        chk({tag, ".m_wdata"}, bus.m_wdata,     64'd0);
        chk({tag, ".rdata"},   bus.rdata,       64'd0);
        chk({tag, ".i_done"},  64'(bus.i_done), 64'd0);
        chk({tag, ".d_done"},  64'(bus.d_done), 64'd0);
        chk({tag, ".err"},     64'(bus.err),    64'd0);
    endtask

    task automatic raise_i(input logic [13:0] a);
        bus.i_req  = 1'b1;
        bus.i_addr = a;
    endtask

    task automatic raise_d(input logic wr, input logic [13:0] a, input logic [63:0] wd);
        bus.d_req   = 1'b1;
        bus.d_wr    = wr;
        bus.d_addr  = a;
        bus.d_wdata = wd;
    endtask

    // Precondition: at a falling edge in an IDLE cycle with at least one req high.
    // lat = BUSY cycle (1-based) in which memory answers; lat > TO means it never answers.
    // Returns at the falling edge of the IDLE cycle that follows the RESP cycle.
    task automatic txn(input int lat, input logic [63:0] rd_val, input string tag);
        bit          exp_d;
        logic        exp_we;
        logic [13:0] exp_addr;
        logic [63:0] exp_wd;
        bit          exp_err;
        int          busy_len;
`ifdef RR_ARB_EN
        exp_d = bus.d_req && (!bus.i_req || !last_d);
`else
        exp_d = bus.d_req;
`endif
        exp_we   = exp_d ? bus.d_wr : 1'b0;
        exp_addr = exp_d ? bus.d_addr : bus.i_addr;
        exp_wd   = bus.d_wdata;
        exp_err  = (lat > TO);
        busy_len = exp_err ? TO : lat;

        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= busy_len; k++) begin
            chk($sformatf("%s.busy%0d.m_re", tag, k), 64'(bus.m_re), 64'(!exp_we));
            chk($sformatf("%s.busy%0d.m_we", tag, k), 64'(bus.m_we), 64'(exp_we));
            chk($sformatf("%s.busy%0d.m_addr", tag, k), 64'(bus.m_addr), 64'(exp_addr));
            if (exp_d)
                chk($sformatf("%s.busy%0d.m_wdata", tag, k), bus.m_wdata, exp_wd);
            chk($sformatf("%s.busy%0d.done", tag, k), 64'({bus.i_done, bus.d_done}), 64'd0);
            bus.m_rdy   = (k == lat);
            bus.m_rdata = (k == lat) ? rd_val : {$urandom, $urandom};
            @(negedge clk);
        end

        // RESP cycle
        chk({tag, ".resp.i_done"}, 64'(bus.i_done), 64'(!exp_d));
        chk({tag, ".resp.d_done"}, 64'(bus.d_done), 64'(exp_d));
        chk({tag, ".resp.err"},    64'(bus.err),    64'(exp_err));
        chk({tag, ".resp.strobes"}, 64'({bus.m_re, bus.m_we}), 64'd0);
        if (!exp_we)
            chk({tag, ".resp.rdata"}, bus.rdata, exp_err ? 64'd0 : rd_val);
        // Late acknowledge arriving outside BUSY must be ignored
        bus.m_rdy   = 1'b1;
        bus.m_rdata = {$urandom, $urandom};
        if (exp_d) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
        last_d = exp_d;

        @(negedge clk);
        chk({tag, ".idle.done"},    64'({bus.i_done, bus.d_done, bus.err}), 64'd0);
        chk({tag, ".idle.strobes"}, 64'({bus.m_re, bus.m_we}), 64'd0);
        chk({tag, ".idle.m_addr"},  64'(bus.m_addr), 64'(exp_addr));
        bus.m_rdy = 1'($urandom % 2);
    endtask

    initial begin
        int lat;
        checks = 0;
        errors = 0;
        last_d = 1'b0;
        rst_n  = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdy = 1'b0; bus.m_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("idle_after_reset");

        // I read alone, memory answers in the 3rd BUSY cycle
        raise_i(14'h0123);
        txn(3, 64'hDEAD_BEEF_0123_4567, "i_read");

        // D write-back, memory answers in the 1st BUSY cycle
        raise_d(1'b1, 14'h3F00, 64'h1111_2222_3333_4444);
        txn(1, {$urandom, $urandom}, "d_wb");

        // Simultaneous requests: both served, none lost
        raise_i(14'h0AAA);
        raise_d(1'b0, 14'h1555, 64'h0);
        txn(2, 64'h0102_0304_0506_0708, "tie_a");
        txn(1, 64'h1112_1314_1516_1718, "tie_b");

        // Three back-to-back tie rounds, then drain the leftover request
        for (int r = 0; r < 3; r++) begin
            if (!bus.i_req) raise_i(14'($urandom));
            if (!bus.d_req) raise_d(1'($urandom % 2), 14'($urandom), {$urandom, $urandom});
            txn(1, {$urandom, $urandom}, $sformatf("tie_round%0d", r));
        end
        if (bus.i_req || bus.d_req) txn(2, {$urandom, $urandom}, "tie_drain");

        // Memory never answers: watchdog aborts a D read
        raise_d(1'b0, 14'h2222, 64'h0);
        txn(TO + 5, 64'hFFFF_FFFF_FFFF_FFFF, "timeout");

        // Reset in the middle of a BUSY I read
        bus.m_rdy = 1'b0;
        raise_i(14'h1234);
        @(posedge clk);
        @(negedge clk);
        chk("midrst.busy.m_re", 64'(bus.m_re), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        bus.i_req = 1'b0;
        rst_n = 1'b1;
        last_d = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.m_rdy = 1'($urandom % 2);
            @(negedge clk);
            chk($sformatf("midrst.after%0d.done", c), 64'({bus.i_done, bus.d_done, bus.m_re}), 64'd0);
        end
        raise_i(14'h0777);
        txn(2, 64'hCAFE_F00D_0000_0001, "post_rst");

        // Randomized rounds with random latencies (some past the watchdog)
        for (int r = 0; r < 40; r++) begin
            if (!bus.i_req && ($urandom % 2 == 1)) raise_i(14'($urandom));
            if (!bus.d_req && (($urandom % 2 == 1) || !bus.i_req))
                raise_d(1'($urandom % 2), 14'($urandom), {$urandom, $urandom});
            lat = $urandom_range(1, TO + 2);
            txn(lat, {$urandom, $urandom}, $sformatf("rnd%0d", r));
        end
        if (bus.i_req || bus.d_req) txn(1, {$urandom, $urandom}, "rnd_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
